// File: rtl/pe_op_sequencer.sv
// rtl/pe_op_sequencer.sv - issue/retire sequencer around a fixed-latency, non-stallable PE
module pe_op_sequencer #(
    parameter int PRECISION = 32,
    parameter int TAG_W     = 8,
    parameter int MULT_LAT  = 10,
    parameter int ADD_LAT   = 25,
    parameter int OUT_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [PRECISION-1:0] in_a,
    input  logic [PRECISION-1:0] in_b,
    input  logic [PRECISION-1:0] in_c,
    output logic [PRECISION-1:0] pe_a,
    output logic [PRECISION-1:0] pe_b,
    output logic [PRECISION-1:0] pe_c,
    input  logic [PRECISION-1:0] pe_mult_result,
    input  logic [PRECISION-1:0] pe_add_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_op,
    output logic [TAG_W-1:0]     out_tag,
    output logic [PRECISION-1:0] out_data,
    output logic                 busy
);
    localparam int CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int ENT_W     = 1 + TAG_W + PRECISION;
    localparam int COL_STAGE = ADD_LAT - MULT_LAT - 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(OUT_DEPTH - 1);

    logic [PRECISION-1:0] pe_a_q, pe_a_d, pe_b_q, pe_b_d, pe_c_q, pe_c_d;
    logic [MULT_LAT-1:0]  mul_vld_q, mul_vld_d;
    logic [TAG_W-1:0]     mul_tag_q [MULT_LAT];
    logic [TAG_W-1:0]     mul_tag_d [MULT_LAT];
    logic [ADD_LAT-1:0]   add_vld_q, add_vld_d;
    logic [TAG_W-1:0]     add_tag_q [ADD_LAT];
    logic [TAG_W-1:0]     add_tag_d [ADD_LAT];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d, infl_cnt_q, infl_cnt_d;
    logic [ENT_W-1:0]     fifo_mem [OUT_DEPTH];

    logic [CNT_W:0]   used;
    logic             collision, accept, pop, fifo_empty, ret_mul, ret_add, wr_en;
    logic [ENT_W-1:0] wr_entry, rd_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Credits count both queued results and ops still inside the PE, so a retire can never overflow.
    assign used      = {1'b0, fifo_cnt_q} + {1'b0, infl_cnt_q};
    // A MULT issued now would retire on the same edge as the MULSUB sitting at this stage.
    assign collision = add_vld_q[COL_STAGE];
    assign in_ready  = rst_n && (used < DEPTH_C) && !(!in_op && collision);
    assign accept    = in_valid && in_ready;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = !fifo_empty && out_ready;
    assign ret_mul    = mul_vld_q[MULT_LAT-1];
    assign ret_add    = add_vld_q[ADD_LAT-1];
    assign wr_en      = ret_mul || ret_add;
    assign wr_entry   = ret_add ? {1'b1, add_tag_q[ADD_LAT-1], pe_add_result}
                                : {1'b0, mul_tag_q[MULT_LAT-1], pe_mult_result};
    assign rd_entry   = fifo_mem[rd_ptr_q];

    assign out_valid = !fifo_empty;
    assign {out_op, out_tag, out_data} = fifo_empty ? '0 : rd_entry;
    assign busy      = (used != '0);
    assign pe_a      = pe_a_q;
    assign pe_b      = pe_b_q;
    assign pe_c      = pe_c_q;

    always_comb begin
        pe_a_d = pe_a_q;
        pe_b_d = pe_b_q;
        pe_c_d = pe_c_q;
        if (accept) begin
            pe_a_d = in_a;
            pe_b_d = in_b;
            pe_c_d = in_c;
        end

        mul_vld_d    = '0;
        mul_tag_d    = mul_tag_q;
        mul_vld_d[0] = accept && !in_op;
        mul_tag_d[0] = in_tag;
        for (int i = 1; i < MULT_LAT; i++) begin
            mul_vld_d[i] = mul_vld_q[i-1];
            mul_tag_d[i] = mul_tag_q[i-1];
        end

        add_vld_d    = '0;
        add_tag_d    = add_tag_q;
        add_vld_d[0] = accept && in_op;
        add_tag_d[0] = in_tag;
        for (int i = 1; i < ADD_LAT; i++) begin
            add_vld_d[i] = add_vld_q[i-1];
            add_tag_d[i] = add_tag_q[i-1];
        end

        wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        infl_cnt_d = infl_cnt_q + CNT_W'(accept) - CNT_W'(wr_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            pe_c_q     <= '0;
            mul_vld_q  <= '0;
            add_vld_q  <= '0;
            for (int i = 0; i < MULT_LAT; i++) mul_tag_q[i] <= '0;
            for (int i = 0; i < ADD_LAT; i++) add_tag_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            infl_cnt_q <= '0;
        end else begin
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            pe_c_q     <= pe_c_d;
            mul_vld_q  <= mul_vld_d;
            add_vld_q  <= add_vld_d;
            mul_tag_q  <= mul_tag_d;
            add_tag_q  <= add_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            infl_cnt_q <= infl_cnt_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= wr_entry;
    end
endmodule

// File: tb/tb_pe_op_sequencer.sv
// tb/tb_pe_op_sequencer.sv - directed vector bench for pe_op_sequencer with a behavioural PE
module tb_pe_op_sequencer;
    localparam int PW = 32;
    localparam int TW = 8;
    localparam int ML = 10;
    localparam int AL = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_op, in_valid, out_ready, in_valid4, out_ready4;
    logic [TW-1:0] in_tag;
    logic [PW-1:0] in_a, in_b, in_c;

    logic          in_ready, out_valid, out_op, busy;
    logic [TW-1:0] out_tag;
    logic [PW-1:0] out_data, pe_a, pe_b, pe_c, pe_mul_r, pe_add_r;

    logic          in_ready4, out_valid4, out_op4, busy4;
    logic [TW-1:0] out_tag4;
    logic [PW-1:0] out_data4, pe_a4, pe_b4, pe_c4, pe_mul_r4, pe_add_r4;

    pe_op_sequencer #(.PRECISION(PW), .TAG_W(TW), .MULT_LAT(ML), .ADD_LAT(AL), .OUT_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
        .pe_mult_result(pe_mul_r), .pe_add_result(pe_add_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_tag(out_tag),
        .out_data(out_data), .busy(busy));

    pe_op_sequencer #(.PRECISION(PW), .TAG_W(TW), .MULT_LAT(ML), .ADD_LAT(AL), .OUT_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op),
        .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .pe_a(pe_a4), .pe_b(pe_b4), .pe_c(pe_c4),
        .pe_mult_result(pe_mul_r4), .pe_add_result(pe_add_r4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_op(out_op4), .out_tag(out_tag4),
        .out_data(out_data4), .busy(busy4));

    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h0F0F1234;
    endfunction

    function automatic logic [31:0] f_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h41200000) return 32'h40800000;
        return c ^ {a[7:0], a[31:8]} ^ b ^ 32'hA5A50000;
    endfunction

    // Behavioural PE: result for operands loaded at edge k is stable just before edge k+LAT.
    logic [PW-1:0] ha [AL-1];
    logic [PW-1:0] hb [AL-1];
    logic [PW-1:0] hc [AL-1];
    logic [PW-1:0] ha4 [AL-1];
    logic [PW-1:0] hb4 [AL-1];
    logic [PW-1:0] hc4 [AL-1];
    always @(posedge clk) begin
        ha[0] <= pe_a;   hb[0] <= pe_b;   hc[0] <= pe_c;
        ha4[0] <= pe_a4; hb4[0] <= pe_b4; hc4[0] <= pe_c4;
        for (int i = 1; i < AL-1; i++) begin
            ha[i] <= ha[i-1];   hb[i] <= hb[i-1];   hc[i] <= hc[i-1];
            ha4[i] <= ha4[i-1]; hb4[i] <= hb4[i-1]; hc4[i] <= hc4[i-1];
        end
    end
    assign pe_mul_r  = f_mul(ha[ML-2], hb[ML-2]);
    assign pe_add_r  = f_sub(ha[AL-2], hb[AL-2], hc[AL-2]);
    assign pe_mul_r4 = f_mul(ha4[ML-2], hb4[ML-2]);
    assign pe_add_r4 = f_sub(ha4[AL-2], hb4[AL-2], hc4[AL-2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic op; logic [TW-1:0] tag; logic [PW-1:0] data; int t; } res_t;
    res_t got[$];
    res_t got4[$];
    int acc4 = 0, pop4 = 0, ovf_viol = 0;
    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back('{out_op, out_tag, out_data, cyc});
        if (out_valid4 && out_ready4) begin
            got4.push_back('{out_op4, out_tag4, out_data4, cyc});
            pop4++;
        end
        if (in_valid4 && in_ready4) acc4++;
        if (acc4 - pop4 > 4) ovf_viol++;
    end

    int n_vec = 0, n_bad = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic op; logic [TW-1:0] tag; logic [PW-1:0] a, b, c, exp; int lat; } vec_t;
    vec_t vt[5];

    task automatic run_vec(input vec_t v, input string nm);
        int t0, w;
        edge1();
        in_valid = 1'b1; in_op = v.op; in_tag = v.tag; in_a = v.a; in_b = v.b; in_c = v.c;
        @(negedge clk);
        check({nm, ".in_ready"}, in_ready, 1);
        edge1();
        in_valid = 1'b0;
        t0 = cyc;
        got.delete();
        w = 0;
        while (got.size() == 0 && w < 60) begin
            @(negedge clk); #1; w++;
        end
        check({nm, ".count"}, got.size(), 1);
        if (got.size() > 0) begin
            check({nm, ".op"}, got[0].op, v.op);
            check({nm, ".tag"}, got[0].tag, v.tag);
            check({nm, ".data"}, got[0].data, v.exp);
            check({nm, ".latency"}, got[0].t - t0, v.lat);
        end
        edge1();
        @(negedge clk);
        check({nm, ".busy_after"}, busy, 0);
        check({nm, ".out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        int t0, w, lows, n, seen;
        logic r;
        vt[0] = '{1'b1, 8'd5,   32'h40000000, 32'h40400000, 32'h41200000, 32'h40800000, AL};
        vt[1] = '{1'b0, 8'd7,   32'h3FC00000, 32'h40000000, 32'h00000000, 32'h40400000, ML};
        vt[2] = '{1'b0, 8'hFF,  32'h40000000, 32'h40400000, 32'h12345678, 32'h40C00000, ML};
        vt[3] = '{1'b1, 8'h00,  32'h3F800000, 32'h0000FFFF, 32'hDEADBEEF, 32'h7B37C110, AL};
        vt[4] = '{1'b0, 8'h80,  32'h00000001, 32'h00010000, 32'h00000000, 32'h0F0F1234, ML};

        rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b0;
        in_op = 1'b0; in_tag = '0; in_a = '0; in_b = '0; in_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", in_ready, 0);
        check("rst.in_ready4", in_ready4, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.out_pkt", {out_op, out_tag, out_data}, 0);
        check("rst.pe_abc", {pe_a, pe_b, pe_c}, 0);
        edge1();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Collision: MULT offered 14 edges after a MULSUB is held off one edge
        edge1();
        in_valid = 1'b1; in_op = 1'b1; in_tag = 8'd1;
        in_a = 32'h11111111; in_b = 32'h22222222; in_c = 32'h33333333;
        edge1();
        t0 = cyc; in_valid = 1'b0; got.delete();
        repeat (14) edge1();
        in_valid = 1'b1; in_op = 1'b0; in_tag = 8'd2;
        in_a = 32'h44444444; in_b = 32'h55555555; in_c = 32'h0;
        @(negedge clk);
        check("col.mult_refused", in_ready, 0);
        in_op = 1'b1; #1;
        check("col.mulsub_ok", in_ready, 1);
        in_op = 1'b0; #1;
        check("col.mult_refused2", in_ready, 0);
        edge1();
        @(negedge clk);
        check("col.mult_next", in_ready, 1);
        edge1();
        in_valid = 1'b0;
        w = 0;
        while (got.size() < 2 && w < 60) begin @(negedge clk); #1; w++; end
        check("col.count", got.size(), 2);
        if (got.size() >= 2) begin
            check("col.first_tag", got[0].tag, 1);
            check("col.first_op", got[0].op, 1);
            check("col.first_t", got[0].t - t0, 25);
            check("col.first_data", got[0].data, f_sub(32'h11111111, 32'h22222222, 32'h33333333));
            check("col.second_tag", got[1].tag, 2);
            check("col.second_op", got[1].op, 0);
            check("col.second_t", got[1].t - t0, 26);
            check("col.second_data", got[1].data, f_mul(32'h44444444, 32'h55555555));
        end

        // Throughput: 100 back-to-back MULSUBs
        got.delete(); lows = 0; t0 = 0;
        edge1();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_op = 1'b1; in_tag = i[7:0];
            in_a = 32'h3F800000 + i; in_b = i << 8; in_c = ~i;
            @(negedge clk);
            if (!in_ready) lows++;
            edge1();
            if (i == 0) t0 = cyc;
        end
        in_valid = 1'b0;
        check("thru.ready_lows", lows, 0);
        w = 0;
        while (got.size() < 100 && w < 200) begin @(negedge clk); #1; w++; end
        check("thru.count", got.size(), 100);
        for (int k = 0; k < 100 && k < got.size(); k++) begin
            check($sformatf("thru.tag%0d", k), got[k].tag, k);
            check($sformatf("thru.t%0d", k), got[k].t - t0, 25 + k);
            check($sformatf("thru.data%0d", k), got[k].data, f_sub(32'h3F800000 + k, k << 8, ~k));
        end

        // Backpressure on the 4-deep instance
        got4.delete(); n = 0;
        edge1();
        in_valid4 = 1'b1; in_op = 1'b1; in_tag = 8'd0;
        in_a = 32'h01020304; in_b = 32'h05060708; in_c = 32'h090A0B0C;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); r = in_ready4;
            edge1();
            if (r) begin n++; in_tag = n[7:0]; end
        end
        @(negedge clk);
        check("bp.accepted_full", n, 4);
        check("bp.in_ready_low", in_ready4, 0);
        check("bp.out_valid", out_valid4, 1);
        check("bp.no_pops", got4.size(), 0);
        edge1();
        out_ready4 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); r = in_ready4;
            edge1();
            if (r) begin n++; in_tag = n[7:0]; end
        end
        in_valid4 = 1'b0;
        check("bp.accepted_total", n, 16);
        w = 0;
        while (got4.size() < n && w < 100) begin @(negedge clk); #1; w++; end
        check("bp.popped_total", got4.size(), n);
        for (int k = 0; k < got4.size(); k++) begin
            check($sformatf("bp.tag%0d", k), got4[k].tag, k);
            check($sformatf("bp.op%0d", k), got4[k].op, 1);
        end
        check("bp.no_overflow", ovf_viol, 0);
        @(negedge clk);
        check("bp.busy_idle", busy4, 0);

        // Reset mid-flight
        out_ready = 1'b0; got.delete();
        edge1();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = (i >= 2); in_tag = 8'h10 + i[7:0];
            in_a = 32'hC0000000 + i; in_b = 32'h00000100; in_c = 32'h00000200;
            @(negedge clk);
            edge1();
        end
        in_valid = 1'b0;
        repeat (8) edge1();
        check("rmid.out_valid_before", out_valid, 1);
        check("rmid.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rmid.out_valid", out_valid, 0);
        check("rmid.busy", busy, 0);
        check("rmid.in_ready", in_ready, 0);
        check("rmid.out_pkt", {out_op, out_tag, out_data}, 0);
        check("rmid.pe_a", pe_a, 0);
        repeat (2) edge1();
        rst_n = 1'b1;
        out_ready = 1'b1; got.delete(); seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rmid.stale_seen", seen, 0);
        check("rmid.stale_popped", got.size(), 0);
        run_vec(vt[1], "rmid.fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
